// File: rtl/pm_pkg.sv
// Shared types for the pattern matcher: compare modes and FSM states.
package pm_pkg;

    typedef enum logic [1:0] {
        MODE_EQ = 2'b00,
        MODE_NE = 2'b01,
        MODE_GT = 2'b10,
        MODE_LT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'b00,
        ST_COUNTING = 2'b01,
        ST_HIT      = 2'b10
    } state_e;

endpackage

// File: rtl/masked_compare.sv
// Combinational masked compare: only bits set in mask take part, and
// GT/LT treat the masked operands as unsigned numbers.
module masked_compare
    import pm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] mask,
    input  mode_e            mode,
    output logic             result
);

    logic [WIDTH-1:0] md;
    logic [WIDTH-1:0] mp;

    assign md = data & mask;
    assign mp = pattern & mask;

    // Select the relation between the masked data and masked pattern.
    always_comb begin
        result = 1'b0;
        case (mode)
            MODE_EQ: result = (md == mp);
            MODE_NE: result = (md != mp);
            MODE_GT: result = (md > mp);
            MODE_LT: result = (md < mp);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/pattern_matcher.sv
// Pattern matcher: registered masked compare of a data stream against a
// configurable pattern, with a run counter, a saturating total counter
// and a sticky hit flag raised when the run reaches a threshold.
module pattern_matcher
    import pm_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               CNT_W         = 8,
    parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(4'b0101)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             hit_clr,
    output logic             match_valid,
    output logic             match,
    output logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic             hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;

    state_e           state_q, state_d;
    logic             match_q, match_d;
    logic             match_valid_q, match_valid_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
    logic             hit_q, hit_d;

    logic             cmp_result;
    logic             valid_match;
    logic             valid_miss;
    logic [CNT_W-1:0] run_upd;
    logic             hit_set;

    masked_compare #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .data   (in_data),
        .pattern(pattern_q),
        .mask   (mask_q),
        .mode   (mode_q),
        .result (cmp_result)
    );

    assign valid_match = in_valid & cmp_result;
    assign valid_miss  = in_valid & ~cmp_result;

    // Configuration registers take the new values only on cfg_load.
    always_comb begin
        pattern_d = pattern_q;
        mask_d    = mask_q;
        mode_d    = mode_q;
        thresh_d  = thresh_q;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            mask_d    = cfg_mask;
            mode_d    = mode_e'(cfg_mode);
            thresh_d  = cfg_thresh;
        end
    end

    // Counters and FSM next state; a same-cycle hit outranks hit_clr, and a
    // same-cycle cfg_load throws away the run update of the sample.
    always_comb begin
        state_d       = state_q;
        hit_d         = hit_q;
        total_cnt_d   = total_cnt_q;
        match_valid_d = in_valid;
        match_d       = match_q;
        run_upd       = run_cnt_q;
        hit_set       = 1'b0;

        if (in_valid) begin
            match_d = cmp_result;
        end

        if (valid_match) begin
            run_upd = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;
            if (total_cnt_q != CNT_MAX) begin
                total_cnt_d = total_cnt_q + CNT_ONE;
            end
        end else if (valid_miss) begin
            run_upd = '0;
        end
        run_cnt_d = run_upd;

        case (state_q)
            ST_ARMED:    if (valid_match) state_d = ST_COUNTING;
            ST_COUNTING: if (valid_miss)  state_d = ST_ARMED;
            ST_HIT:      hit_d = 1'b1;
            default:     state_d = ST_ARMED;
        endcase

        hit_set = valid_match && (state_q != ST_HIT) && !cfg_load &&
                  (thresh_q != '0) && (run_upd == thresh_q);

        if (hit_clr) begin
            state_d   = ST_ARMED;
            hit_d     = 1'b0;
            run_cnt_d = '0;
        end

        if (cfg_load) begin
            run_cnt_d = '0;
            if (state_q != ST_HIT) begin
                state_d = ST_ARMED;
            end
        end

        if (hit_set) begin
            state_d   = ST_HIT;
            run_cnt_d = run_upd;
        end
    end

    // All state registers; reset restores the equality-to-RESET_PATTERN setup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q     <= RESET_PATTERN;
            mask_q        <= '1;
            mode_q        <= MODE_EQ;
            thresh_q      <= CNT_ONE;
            state_q       <= ST_ARMED;
            match_q       <= 1'b0;
            match_valid_q <= 1'b0;
            run_cnt_q     <= '0;
            total_cnt_q   <= '0;
            hit_q         <= 1'b0;
        end else begin
            pattern_q     <= pattern_d;
            mask_q        <= mask_d;
            mode_q        <= mode_d;
            thresh_q      <= thresh_d;
            state_q       <= state_d;
            match_q       <= match_d;
            match_valid_q <= match_valid_d;
            run_cnt_q     <= run_cnt_d;
            total_cnt_q   <= total_cnt_d;
            hit_q         <= hit_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match       = match_q;
    assign run_cnt     = run_cnt_q;
    assign total_cnt   = total_cnt_q;
    assign hit         = hit_q;

endmodule

// File: tb/tb_pattern_matcher.sv
// Directed bench for pattern_matcher: a default 8-bit-counter instance and a
// 2-bit-counter instance driven by the same stimulus.
module tb_pattern_matcher;

    logic       clk;
    logic       reset;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic [3:0] cfg_mask;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_thresh;
    logic       in_valid;
    logic [3:0] in_data;
    logic       hit_clr;

    logic       match_valid, match, hit;
    logic [7:0] run_cnt, total_cnt;
    logic       match_valid_s, match_s, hit_s;
    logic [1:0] run_cnt_s, total_cnt_s;

    int n_checks = 0;
    int n_bad    = 0;

    pattern_matcher dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_data(in_data), .hit_clr(hit_clr),
        .match_valid(match_valid), .match(match), .run_cnt(run_cnt),
        .total_cnt(total_cnt), .hit(hit)
    );

    pattern_matcher #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh[1:0]),
        .in_valid(in_valid), .in_data(in_data), .hit_clr(hit_clr),
        .match_valid(match_valid_s), .match(match_s), .run_cnt(run_cnt_s),
        .total_cnt(total_cnt_s), .hit(hit_s)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a configuration for one edge with in_valid low.
    task automatic load_cfg(input logic [3:0] pat, input logic [3:0] msk,
                            input logic [1:0] mode, input logic [7:0] thr);
        cfg_pattern = pat; cfg_mask = msk; cfg_mode = mode; cfg_thresh = thr;
        in_valid = 1'b0; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_match got=%0b want=0", match); end
        n_checks++; if (match_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mvalid got=%0b want=0", match_valid); end
        n_checks++; if (run_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL rst_run got=%0d want=0", run_cnt); end
        n_checks++; if (total_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL rst_total got=%0d want=0", total_cnt); end
        n_checks++; if (hit !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_hit got=%0b want=0", hit); end
    endtask

    task automatic test_default_detector();
        in_valid = 1'b1; in_data = 4'b0101;
        tick();
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL dflt_match1 got=%0b want=1", match); end
        n_checks++; if (match_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL dflt_mvalid got=%0b want=1", match_valid); end
        n_checks++; if (run_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL dflt_run1 got=%0d want=1", run_cnt); end
        n_checks++; if (hit !== 1'b0) begin n_bad++; $display("[TB] FAIL dflt_hit_early got=%0b want=0", hit); end
        in_data = 4'b0100;
        tick();
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL dflt_match0 got=%0b want=0", match); end
        n_checks++; if (run_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL dflt_run0 got=%0d want=0", run_cnt); end
        n_checks++; if (hit !== 1'b1) begin n_bad++; $display("[TB] FAIL dflt_hit got=%0b want=1", hit); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (hit !== 1'b1) begin n_bad++; $display("[TB] FAIL dflt_hit_sticky got=%0b want=1", hit); end
        hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
        n_checks++; if (hit !== 1'b0) begin n_bad++; $display("[TB] FAIL dflt_hit_clr got=%0b want=0", hit); end
    endtask

    task automatic test_masked_threshold();
        logic [3:0] vec [3];
        vec[0] = 4'b0111; vec[1] = 4'b0100; vec[2] = 4'b0110;
        load_cfg(4'b0100, 4'b1100, 2'b00, 8'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vec[i];
            tick();
            n_checks++; if (run_cnt !== 8'(i + 1)) begin n_bad++; $display("[TB] FAIL mask_run%0d got=%0d want=%0d", i, run_cnt, i + 1); end
            n_checks++; if (hit !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_hit_early%0d got=%0b want=0", i, hit); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (hit !== 1'b1) begin n_bad++; $display("[TB] FAIL mask_hit got=%0b want=1", hit); end
        n_checks++; if (match_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_mvalid_idle got=%0b want=0", match_valid); end
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL mask_match_hold got=%0b want=1", match); end
        n_checks++; if (run_cnt !== 8'd3) begin n_bad++; $display("[TB] FAIL mask_run_hold got=%0d want=3", run_cnt); end
        in_valid = 1'b1; in_data = 4'b1111;
        tick();
        n_checks++; if (run_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL mask_run_miss got=%0d want=0", run_cnt); end
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_match_miss got=%0b want=0", match); end
        n_checks++; if (hit !== 1'b1) begin n_bad++; $display("[TB] FAIL mask_hit_stays got=%0b want=1", hit); end
        n_checks++; if (total_cnt !== 8'd4) begin n_bad++; $display("[TB] FAIL mask_total got=%0d want=4", total_cnt); end
        in_valid = 1'b0; hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
    endtask

    task automatic test_modes();
        load_cfg(4'b0101, 4'b1111, 2'b10, 8'd0);
        in_valid = 1'b1; in_data = 4'b0110;
        tick();
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL gt_above got=%0b want=1", match); end
        in_data = 4'b0101;
        tick();
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL gt_equal got=%0b want=0", match); end
        load_cfg(4'b0101, 4'b1111, 2'b11, 8'd0);
        in_valid = 1'b1; in_data = 4'b0000;
        tick();
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL lt_below got=%0b want=1", match); end
        in_data = 4'b1000;
        tick();
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL lt_above got=%0b want=0", match); end
        load_cfg(4'b0101, 4'b1111, 2'b01, 8'd0);
        in_valid = 1'b1; in_data = 4'b0101;
        tick();
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL ne_equal got=%0b want=0", match); end
        in_data = 4'b0011;
        tick();
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL ne_diff got=%0b want=1", match); end
        n_checks++; if (hit !== 1'b0) begin n_bad++; $display("[TB] FAIL mode_nohit got=%0b want=0", hit); end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_s;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        load_cfg(4'b0101, 4'b1111, 2'b00, 8'd0);
        in_valid = 1'b1; in_data = 4'b0101;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_s = (i > 3) ? 3 : i;
            n_checks++; if (run_cnt_s !== 2'(exp_s)) begin n_bad++; $display("[TB] FAIL sat_run%0d got=%0d want=%0d", i, run_cnt_s, exp_s); end
            n_checks++; if (total_cnt_s !== 2'(exp_s)) begin n_bad++; $display("[TB] FAIL sat_total%0d got=%0d want=%0d", i, total_cnt_s, exp_s); end
            n_checks++; if (hit_s !== 1'b0) begin n_bad++; $display("[TB] FAIL sat_hit%0d got=%0b want=0", i, hit_s); end
            n_checks++; if (run_cnt !== 8'(i)) begin n_bad++; $display("[TB] FAIL wide_run%0d got=%0d want=%0d", i, run_cnt, i); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (hit !== 1'b0) begin n_bad++; $display("[TB] FAIL thr0_hit got=%0b want=0", hit); end
    endtask

    task automatic test_back_to_back();
        load_cfg(4'b0101, 4'b1111, 2'b00, 8'd2);
        in_valid = 1'b1; in_data = 4'b0101;
        tick();
        hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++; if (hit !== 1'b1) begin n_bad++; $display("[TB] FAIL clr_vs_set_hit got=%0b want=1", hit); end
        hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
        cfg_pattern = 4'b1010; cfg_load = 1'b1; in_valid = 1'b1; in_data = 4'b0101;
        tick();
        cfg_load = 1'b0;
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL load_old_match got=%0b want=1", match); end
        n_checks++; if (run_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL load_run_clr got=%0d want=0", run_cnt); end
        in_data = 4'b1010;
        tick();
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL load_new_match got=%0b want=1", match); end
        n_checks++; if (run_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL load_new_run got=%0d want=1", run_cnt); end
        in_data = 4'b0101;
        tick();
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL load_old_gone got=%0b want=0", match); end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        load_cfg(4'b0101, 4'b1111, 2'b00, 8'd2);
        in_valid = 1'b1; in_data = 4'b0101;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++; if (run_cnt !== 8'd2) begin n_bad++; $display("[TB] FAIL ares_pre_run got=%0d want=2", run_cnt); end
        n_checks++; if (hit !== 1'b1) begin n_bad++; $display("[TB] FAIL ares_pre_hit got=%0b want=1", hit); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (run_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL ares_run got=%0d want=0", run_cnt); end
        n_checks++; if (total_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL ares_total got=%0d want=0", total_cnt); end
        n_checks++; if (hit !== 1'b0) begin n_bad++; $display("[TB] FAIL ares_hit got=%0b want=0", hit); end
        n_checks++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL ares_match got=%0b want=0", match); end
        n_checks++; if (match_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ares_mvalid got=%0b want=0", match_valid); end
        #1;
        reset = 1'b0;
        in_valid = 1'b1; in_data = 4'b0101;
        tick();
        n_checks++; if (run_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL fresh_run got=%0d want=1", run_cnt); end
        n_checks++; if (total_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL fresh_total got=%0d want=1", total_cnt); end
        n_checks++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL fresh_match got=%0b want=1", match); end
        in_valid = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '0;
        cfg_mode = '0; cfg_thresh = '0; in_valid = 1'b0; in_data = '0; hit_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_default_detector();
        test_masked_threshold();
        test_modes();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
